// File: rtl/tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_decoder
//
// Purpose:
//   Receive-side decoder for one TMDS channel. Each pixel clock it accepts one
//   parallel 10-bit TMDS symbol and recovers:
//     - the 8-bit pixel byte (data periods),
//     - the 2-bit control value (control tokens), and
//     - data-enable.
//   It also tracks control-period lock and checks the running disparity of
//   data symbols since the last control token.
//
//   The pipeline has two stages, so valid_o follows symbol_valid_i by exactly
//   two cycles:
//     - Stage 1 classifies each symbol (token or data), decodes it and
//       computes its disparity.
//     - Stage 2 accumulates disparity, updates the lock FSM and registers the
//       outputs.
//   Cycles with symbol_valid_i=0 flow through as bubbles and do not touch any
//   state.
//
// Parameters:
//   LOCK_COUNT    consecutive control tokens needed to enter LOCKED
//   UNLOCK_COUNT  consecutive erroring symbols in LOCKED that force UNLOCKED
//   DISP_LIMIT    largest allowed |running disparity| since the last token
//
// Ports:
//   clk_pixel       in   1   pixel clock, rising edge
//   reset_n_i       in   1   asynchronous active-low reset
//   symbol_i        in  10   TMDS symbol, bit 0 first on the wire
//   symbol_valid_i  in   1   symbol_i valid this cycle
//   err_clr_i       in   1   clears err_count_o (error-count feature only)
//   data_o          out  8   decoded pixel byte (0 on control tokens)
//   ctrl_o          out  2   last decoded control value {C1,C0}
//   de_o            out  1   1 = data symbol, 0 = control token
//   valid_o         out  1   outputs valid this cycle
//   err_o           out  1   symbol presented with this valid_o had an error
//   locked_o        out  1   lock FSM is in LOCKED
//   err_count_o     out 16   saturating count of errors seen while locked
//
// Optional feature macro:
//   TMDS_ERR_COUNT_EN
//     Defined:   builds the saturating error counter.
//     Undefined: err_count_o is tied to 0 and err_clr_i is ignored.
// -----------------------------------------------------------------------------
module tmds_channel_decoder #(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int DISP_LIMIT   = 20
) (
  input  logic        clk_pixel,
  input  logic        reset_n_i,
  input  logic [9:0]  symbol_i,
  input  logic        symbol_valid_i,
  input  logic        err_clr_i,
  output logic [7:0]  data_o,
  output logic [1:0]  ctrl_o,
  output logic        de_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        locked_o,
  output logic [15:0] err_count_o
);

  localparam int LockW   = $clog2(LOCK_COUNT + 1);
  localparam int UnlockW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // ---------------------------------------------------------------------------
  // Stage 1: classify, decode and measure disparity
  // ---------------------------------------------------------------------------

  logic              token_d;
  logic [1:0]        tok_ctrl_d;
  logic [7:0]        dec_data_d;
  logic [7:0]        q_word;
  logic [3:0]        ones_d;
  logic signed [5:0] sym_disp_d;

  always_comb begin
    token_d    = 1'b1;
    tok_ctrl_d = 2'b00;
    case (symbol_i)
      10'h354: tok_ctrl_d = 2'b00;
      10'h0AB: tok_ctrl_d = 2'b01;
      10'h154: tok_ctrl_d = 2'b10;
      10'h2AB: tok_ctrl_d = 2'b11;
      default: token_d    = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then undo the XOR/XNOR chain (bit 8)
  // between neighbouring bits.
  always_comb begin
    q_word        = symbol_i[9] ? ~symbol_i[7:0] : symbol_i[7:0];
    dec_data_d    = 8'h00;
    dec_data_d[0] = q_word[0];
    for (int i = 1; i < 8; i++) begin
      dec_data_d[i] = symbol_i[8] ? (q_word[i] ^ q_word[i-1])
                                  : ~(q_word[i] ^ q_word[i-1]);
    end
  end

  // Symbol disparity = 2 * ones - 10, which lies in -10..+10.
  always_comb begin
    ones_d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      ones_d = ones_d + {3'b000, symbol_i[i]};
    end
    sym_disp_d = $signed({1'b0, ones_d, 1'b0}) - 6'sd10;
  end

  logic              s1_valid_q;
  logic              s1_token_q;
  logic [1:0]        s1_ctrl_q;
  logic [7:0]        s1_data_q;
  logic signed [5:0] s1_disp_q;

  always_ff @(posedge clk_pixel or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid_q <= 1'b0;
      s1_token_q <= 1'b0;
      s1_ctrl_q  <= 2'b00;
      s1_data_q  <= 8'h00;
      s1_disp_q  <= 6'sd0;
    end else begin
      s1_valid_q <= symbol_valid_i;
      if (symbol_valid_i) begin
        s1_token_q <= token_d;
        s1_ctrl_q  <= tok_ctrl_d;
        s1_data_q  <= dec_data_d;
        s1_disp_q  <= sym_disp_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: running disparity, lock FSM, output registers
  // ---------------------------------------------------------------------------

  lock_state_e       state_q;
  logic [LockW-1:0]   lock_cnt_q;
  logic [UnlockW-1:0] err_run_q;
  logic signed [6:0] disp_sum_q;
  logic signed [6:0] disp_sum_d;
  logic signed [7:0] sum_wide;
  logic [6:0]        sum_mag;
  logic              sym_err_d;

  logic [7:0] data_q;
  logic [1:0] ctrl_q;
  logic       de_q;
  logic       valid_q;
  logic       err_q;
  logic       locked_q;

  // The running sum saturates at +/-63. Control tokens restart it at 0.
  // The error check uses the updated (saturated) sum.
  always_comb begin
    sum_wide   = $signed({disp_sum_q[6], disp_sum_q})
               + $signed({{2{s1_disp_q[5]}}, s1_disp_q});
    disp_sum_d = disp_sum_q;
    if (s1_valid_q) begin
      if (s1_token_q) begin
        disp_sum_d = 7'sd0;
      end else if (sum_wide > 8'sd63) begin
        disp_sum_d = 7'sd63;
      end else if (sum_wide < -8'sd63) begin
        disp_sum_d = -7'sd63;
      end else begin
        disp_sum_d = sum_wide[6:0];
      end
    end
    sum_mag   = disp_sum_d[6] ? -disp_sum_d : disp_sum_d;
    sym_err_d = s1_valid_q && !s1_token_q && (sum_mag > 7'(DISP_LIMIT));
  end

  always_ff @(posedge clk_pixel or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      err_run_q  <= '0;
      disp_sum_q <= 7'sd0;
      data_q     <= 8'h00;
      ctrl_q     <= 2'b00;
      de_q       <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        disp_sum_q <= disp_sum_d;
        err_q      <= sym_err_d;
        de_q       <= ~s1_token_q;
        if (s1_token_q) begin
          ctrl_q <= s1_ctrl_q;
          data_q <= 8'h00;
        end else begin
          data_q <= s1_data_q;
        end

        if (state_q == UNLOCKED) begin
          // Only an unbroken run of tokens counts toward lock.
          if (s1_token_q) begin
            if (lock_cnt_q == LockW'(LOCK_COUNT - 1)) begin
              state_q    <= LOCKED;
              locked_q   <= 1'b1;
              lock_cnt_q <= '0;
              err_run_q  <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q + LockW'(1);
            end
          end else begin
            lock_cnt_q <= '0;
          end
        end else begin
          // Only an unbroken run of erroring symbols drops lock. Tokens
          // never error, so they also break the run.
          if (sym_err_d) begin
            if (err_run_q == UnlockW'(UNLOCK_COUNT - 1)) begin
              state_q    <= UNLOCKED;
              locked_q   <= 1'b0;
              err_run_q  <= '0;
              lock_cnt_q <= '0;
            end else begin
              err_run_q <= err_run_q + UnlockW'(1);
            end
          end else begin
            err_run_q <= '0;
          end
        end
      end
    end
  end

  assign data_o   = data_q;
  assign ctrl_o   = ctrl_q;
  assign de_o     = de_q;
  assign valid_o  = valid_q;
  assign err_o    = err_q;
  assign locked_o = locked_q;

  // ---------------------------------------------------------------------------
  // Optional saturating error counter
  // ---------------------------------------------------------------------------
`ifdef TMDS_ERR_COUNT_EN
  logic [15:0] err_count_q;
  logic        err_count_inc;

  // Count an error only if the FSM is still LOCKED after this symbol. The
  // error that drops lock is therefore not counted.
  assign err_count_inc = sym_err_d && (state_q == LOCKED)
                      && (err_run_q != UnlockW'(UNLOCK_COUNT - 1));

  always_ff @(posedge clk_pixel or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_count_q <= 16'h0000;
    end else if (err_clr_i) begin
      err_count_q <= 16'h0000;
    end else if (err_count_inc && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count_o = err_count_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr_i;
  assign err_count_o    = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
module tb_tmds_channel_decoder;

  localparam int LOCK_COUNT   = 8;
  localparam int UNLOCK_COUNT = 4;
  localparam int DISP_LIMIT   = 20;

  logic        clk_pixel = 1'b0;
  logic        reset_n_i;
  logic [9:0]  symbol_i;
  logic        symbol_valid_i;
  logic        err_clr_i;
  logic [7:0]  data_o;
  logic [1:0]  ctrl_o;
  logic        de_o;
  logic        valid_o;
  logic        err_o;
  logic        locked_o;
  logic [15:0] err_count_o;

  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_decoder #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT),
    .DISP_LIMIT  (DISP_LIMIT)
  ) dut (
    .clk_pixel     (clk_pixel),
    .reset_n_i     (reset_n_i),
    .symbol_i      (symbol_i),
    .symbol_valid_i(symbol_valid_i),
    .err_clr_i     (err_clr_i),
    .data_o        (data_o),
    .ctrl_o        (ctrl_o),
    .de_o          (de_o),
    .valid_o       (valid_o),
    .err_o         (err_o),
    .locked_o      (locked_o),
    .err_count_o   (err_count_o)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  data;
    logic [1:0]  ctrl;
    logic        de;
    logic        err;
    logic        locked;
    logic [15:0] errCount;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCount  = 0;

  // Reference model state.
  int       mCtrl, mSum, mLockCnt, mErrRun, mErrCnt;
  bit       mLocked;

  always @(posedge clk_pixel) cycleCount++;

  task automatic modelReset();
    mCtrl = 0; mSum = 0; mLockCnt = 0; mErrRun = 0; mErrCnt = 0; mLocked = 0;
  endtask

  task automatic checkField(input string name, input int act, input int expv);
    testsRun++;
    if (act != expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cycleCount);
    end
  endtask

  function automatic int tokenValue(input logic [9:0] s);
    case (s)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  // Forward TMDS transition-minimising step, used to search for the byte that
  // would have produced the received word.
  function automatic logic [7:0] encodeQm(input logic [7:0] d, input logic useXor);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = useXor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    return qm;
  endfunction

  function automatic logic [7:0] decodeRef(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] cand;
    q = s[9] ? ~s[7:0] : s[7:0];
    for (int c = 0; c < 256; c++) begin
      cand = 8'(c);
      if (encodeQm(cand, s[8]) == q) return cand;
    end
    return 8'h00;
  endfunction

  function automatic int disparity(input logic [9:0] s);
    int ones = 0;
    for (int i = 0; i < 10; i++) if (s[i]) ones++;
    return 2 * ones - 10;
  endfunction

  task automatic modelSymbol(input logic [9:0] s, input int cyc);
    exp_t e;
    int   tok;
    tok   = tokenValue(s);
    e.cyc = cyc;
    if (tok >= 0) begin
      mCtrl   = tok;
      mSum    = 0;
      e.data  = 8'h00;
      e.de    = 1'b0;
      e.err   = 1'b0;
      mErrRun = 0;
      if (!mLocked) begin
        mLockCnt++;
        if (mLockCnt == LOCK_COUNT) begin
          mLocked  = 1;
          mLockCnt = 0;
        end
      end
    end else begin
      e.data = decodeRef(s);
      e.de   = 1'b1;
      mSum   = mSum + disparity(s);
      if (mSum > 63)  mSum = 63;
      if (mSum < -63) mSum = -63;
      e.err  = (mSum > DISP_LIMIT) || (mSum < -DISP_LIMIT);
      if (!mLocked) begin
        mLockCnt = 0;
      end else if (e.err) begin
        mErrRun++;
        if (mErrRun == UNLOCK_COUNT) begin
          mLocked  = 0;
          mErrRun  = 0;
          mLockCnt = 0;
        end
      end else begin
        mErrRun = 0;
      end
    end
`ifdef TMDS_ERR_COUNT_EN
    if (e.err && mLocked && mErrCnt < 16'hFFFF) mErrCnt++;
`endif
    e.ctrl     = 2'(mCtrl);
    e.locked   = mLocked;
    e.errCount = 16'(mErrCnt);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic valid, input logic [9:0] s);
    @(posedge clk_pixel);
    #1;
    symbol_valid_i = valid;
    symbol_i       = valid ? s : 10'($urandom);
    if (valid) modelSymbol(s, cycleCount + 2);
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("latency",  cycleCount, e.cyc);
    checkField("data_o",   int'(data_o),   int'(e.data));
    checkField("ctrl_o",   int'(ctrl_o),   int'(e.ctrl));
    checkField("de_o",     int'(de_o),     int'(e.de));
    checkField("err_o",    int'(err_o),    int'(e.err));
    checkField("locked_o", int'(locked_o), int'(e.locked));
    checkField("err_count_o", int'(err_count_o), int'(e.errCount));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkField({tag, " valid_o"},     int'(valid_o),     0);
    checkField({tag, " data_o"},      int'(data_o),      0);
    checkField({tag, " ctrl_o"},      int'(ctrl_o),      0);
    checkField({tag, " de_o"},        int'(de_o),        0);
    checkField({tag, " err_o"},       int'(err_o),       0);
    checkField({tag, " locked_o"},    int'(locked_o),    0);
    checkField({tag, " err_count_o"}, int'(err_count_o), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output, and
  // flags outputs that are missing or unexpected.
  always @(negedge clk_pixel) begin
    exp_t e;
    if (reset_n_i) begin
      if (valid_o) begin
        if (expQ.size() == 0) begin
          checkField("unexpected valid_o", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput(e);
        end
      end else if (expQ.size() > 0 && expQ[0].cyc <= cycleCount) begin
        checkField("missing valid_o", 0, 1);
        void'(expQ.pop_front());
      end
    end
  end

  function automatic logic [9:0] randomData();
    return 10'($urandom);
  endfunction

  function automatic logic [9:0] skewedData();
    case ($urandom_range(0, 3))
      0:       return 10'h3FF;
      1:       return 10'h000;
      2:       return 10'h03F;
      default: return 10'h3C0;
    endcase
  endfunction

  function automatic logic [9:0] randomToken();
    case ($urandom_range(0, 3))
      0:       return 10'h354;
      1:       return 10'h0AB;
      2:       return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  logic [9:0] dirSeq[] = '{
    10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354,
    10'h100, 10'h3FF,
    10'h0AB, 10'h154, 10'h2AB, 10'h155,
    10'h354, 10'h3FF, 10'h3FF, 10'h3FF,
    10'h3FF, 10'h3FF, 10'h3FF,
    10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354,
    10'h3FF, 10'h3FF, 10'h03F, 10'h03F, 10'h03F, 10'h000,
    10'h354
  };

  initial begin
    int kind;
    int len;
    modelReset();
    reset_n_i      = 1'b0;
    symbol_i       = 10'h000;
    symbol_valid_i = 1'b0;
    err_clr_i      = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1;
    checkResetOutputs("reset");
    #2 reset_n_i = 1'b1;

    // Directed sequence: lock, decode, tokens, error runs, relock.
    foreach (dirSeq[i]) applyStimulus(1'b1, dirSeq[i]);
    repeat (4) applyStimulus(1'b0, 10'h000);

`ifdef TMDS_ERR_COUNT_EN
    @(posedge clk_pixel);
    #1 err_clr_i = 1'b1;
    @(posedge clk_pixel);
    #1 err_clr_i = 1'b0;
    mErrCnt = 0;
    checkField("err_clr", int'(err_count_o), 0);
`endif

    // Randomised bursts of tokens, arbitrary data and disparity-skewed data.
    for (int b = 0; b < 200; b++) begin
      kind = $urandom_range(0, 2);
      len  = (kind == 0) ? $urandom_range(1, 12) : $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 10'h000);
        case (kind)
          0:       applyStimulus(1'b1, randomToken());
          1:       applyStimulus(1'b1, randomData());
          default: applyStimulus(1'b1, skewedData());
        endcase
      end
    end

    // Lock up, then reset asynchronously in the middle of a gapped stream.
    repeat (LOCK_COUNT) applyStimulus(1'b1, 10'h354);
    for (int i = 0; i < 10; i++) applyStimulus(i % 2 == 0, randomData());
    #3 reset_n_i = 1'b0;
    symbol_valid_i = 1'b0;
    expQ.delete();
    modelReset();
    #1;
    checkResetOutputs("async reset");
    @(posedge clk_pixel);
    @(posedge clk_pixel);
    #3 reset_n_i = 1'b1;

    // Gapped tokens after release: lock only on the eighth new token.
    for (int i = 0; i < 2 * LOCK_COUNT + 2; i++) applyStimulus(i % 2 == 0, randomToken());
    for (int i = 0; i < 6; i++) applyStimulus(i % 2 == 0, randomData());

    repeat (6) applyStimulus(1'b0, 10'h000);
    checkField("scoreboard drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
